// File: rtl/capture_ctrl.sv
// capture_ctrl: capture-side sequencer for the channel sample RAMs; define CAPTURE_AUTOTRIG_EN to enable the timeout auto-trigger
module capture_ctrl #(
  parameter int DEPTH   = 384,
  parameter int AW      = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          smpl_en,
  input  logic          arm,
  input  logic          trigger,
  input  logic [AW-1:0] trig_pos,
  input  logic          dump_active,
  input  logic          clr_done,
  output logic          we,
  output logic          cap_en,
  output logic [AW-1:0] cap_addr,
  output logic [AW-1:0] trace_end,
  output logic          armed,
  output logic          capture_done,
  output logic          auto_trig
);
  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef CAPTURE_AUTOTRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic [2:0] state_q, state_d;
  logic [AW-1:0] tp_q, tp_d, wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d;
  logic [AW-1:0] trace_end_q, trace_end_d, cap_addr_q, cap_addr_d, last_addr;
  logic [AW:0] pre_cnt_q, pre_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic we_q, we_d, cap_en_q, cap_en_d, armed_q, armed_d, done_q, done_d, auto_trig_q, auto_trig_d;
  logic accept, wr, timeout, fire;
  // arm is taken from IDLE, or from DONE together with clr_done (re-arm)
  assign accept = arm && !dump_active && (state_q == IDLE || (state_q == DONE && clr_done));
  // once the post-trigger quota is met, further strobes must not overwrite the trace
  assign wr = smpl_en && (state_q == PRE || state_q == ARMED || (state_q == POST && post_cnt_q != tp_q));
  assign timeout = AUTO && state_q == ARMED && smpl_en && to_cnt_q == TW'(TIMEOUT - 1);
  assign fire = state_q == ARMED && (trigger || timeout);
  assign last_addr = wr_ptr_q == '0 ? LAST : wr_ptr_q - 1'b1;
  // next-state, counters and registered-output values
  always_comb begin
    state_d = state_q;
    tp_d = tp_q;
    wr_ptr_d = wr ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    pre_cnt_d = (wr && pre_cnt_q != FULL) ? pre_cnt_q + 1'b1 : pre_cnt_q;
    post_cnt_d = (wr && state_q == POST) ? post_cnt_q + 1'b1 : post_cnt_q;
    to_cnt_d = state_q == ARMED ? to_cnt_q + TW'(smpl_en) : '0;
    trace_end_d = trace_end_q;
    auto_trig_d = auto_trig_q;
    cap_addr_d = wr ? wr_ptr_q : cap_addr_q;
    cap_en_d = wr;
    if (state_q == PRE && pre_cnt_d >= FULL - {1'b0, tp_q}) state_d = ARMED;
    if (fire) begin
      state_d = (tp_q == '0 && !smpl_en) ? DONE : POST;
      auto_trig_d = !trigger;
    end
    if (state_q == POST && post_cnt_q == tp_q) state_d = DONE;
    if (state_d == DONE && state_q != DONE) trace_end_d = last_addr;
    if (state_q == DONE && clr_done) state_d = IDLE;
    if (accept) begin
      state_d = PRE;
      tp_d = trig_pos > LAST ? LAST : trig_pos;
      pre_cnt_d = '0;
      post_cnt_d = '0;
      wr_ptr_d = '0;
      auto_trig_d = 1'b0;
    end
    we_d = state_d == PRE || state_d == ARMED || state_d == POST;
    armed_d = state_d == ARMED;
    done_d = state_d == DONE;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tp_q <= '0;
      wr_ptr_q <= '0;
      pre_cnt_q <= '0;
      post_cnt_q <= '0;
      to_cnt_q <= '0;
      trace_end_q <= '0;
      cap_addr_q <= '0;
      cap_en_q <= 1'b0;
      we_q <= 1'b0;
      armed_q <= 1'b0;
      done_q <= 1'b0;
      auto_trig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tp_q <= tp_d;
      wr_ptr_q <= wr_ptr_d;
      pre_cnt_q <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      to_cnt_q <= to_cnt_d;
      trace_end_q <= trace_end_d;
      cap_addr_q <= cap_addr_d;
      cap_en_q <= cap_en_d;
      we_q <= we_d;
      armed_q <= armed_d;
      done_q <= done_d;
      auto_trig_q <= auto_trig_d;
    end
  end
  assign we = we_q;
  assign cap_en = cap_en_q;
  assign cap_addr = cap_addr_q;
  assign trace_end = trace_end_q;
  assign armed = armed_q;
  assign capture_done = done_q;
  assign auto_trig = auto_trig_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized bench for capture_ctrl against a write-count reference model
module tb_capture_ctrl;
  localparam int D = 384;
  localparam int AW = 9;
  localparam int TO = 16;
  localparam int BIG = 1 << 30;
`ifdef CAPTURE_AUTOTRIG_EN
  localparam bit M_AUTO = 1'b1;
`else
  localparam bit M_AUTO = 1'b0;
`endif
  logic clk = 1'b0, rst_n, smpl_en, arm, trigger, dump_active, clr_done;
  logic [AW-1:0] trig_pos, cap_addr, trace_end;
  logic we, cap_en, armed, capture_done, auto_trig;
  int n_chk = 0, n_pass = 0;
  int m_ph, m_n, m_trig, m_tp, m_tcnt, e_addr, e_end, armed_at;
  bit e_we, e_cap_en, e_armed, e_done, e_auto, armed_prev;

  capture_ctrl #(.DEPTH(D), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .smpl_en(smpl_en), .arm(arm), .trigger(trigger),
    .trig_pos(trig_pos), .dump_active(dump_active), .clr_done(clr_done),
    .we(we), .cap_en(cap_en), .cap_addr(cap_addr), .trace_end(trace_end),
    .armed(armed), .capture_done(capture_done), .auto_trig(auto_trig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_ph = 0; m_n = 0; m_trig = -1; m_tp = 0; m_tcnt = 0;
    e_we = 0; e_cap_en = 0; e_armed = 0; e_done = 0; e_auto = 0; e_addr = 0; e_end = 0;
  endtask

  // phases: 0 idle, 1 capturing, 2 trace complete; a trace is described by write count and trigger point
  task automatic mdl();
    int ph0;
    bit arm_ph, full, wr, to;
    ph0 = m_ph;
    arm_ph = m_ph == 1 && m_trig < 0 && m_n >= D - m_tp;
    full = m_ph == 1 && m_trig >= 0 && m_n == m_trig + m_tp;
    wr = m_ph == 1 && smpl_en && !full;
    to = 0;
    e_cap_en = wr;
    if (wr) begin e_addr = m_n % D; m_n++; end
    if (arm_ph && smpl_en) begin m_tcnt++; to = M_AUTO && m_tcnt == TO; end
    if (full) begin m_ph = 2; e_end = (m_n - 1) % D; end
    else if (arm_ph && (trigger || to)) begin
      m_trig = m_n;
      e_auto = !trigger;
      if (m_tp == 0 && !wr) begin m_ph = 2; e_end = (m_n - 1) % D; end
    end
    if (ph0 == 2 && clr_done) m_ph = 0;
    if (arm && !dump_active && (ph0 == 0 || (ph0 == 2 && clr_done))) begin
      m_ph = 1; m_n = 0; m_trig = -1; m_tcnt = 0; e_auto = 0;
      m_tp = trig_pos > D - 1 ? D - 1 : int'(trig_pos);
    end
    e_we = m_ph == 1;
    e_armed = m_ph == 1 && m_trig < 0 && m_n >= D - m_tp;
    e_done = m_ph == 2;
  endtask

  task automatic compare();
    check("we", we, e_we);
    check("cap_en", cap_en, e_cap_en);
    if (e_cap_en) check("cap_addr", cap_addr, e_addr);
    check("trace_end", trace_end, e_end);
    check("armed", armed, e_armed);
    check("capture_done", capture_done, e_done);
    check("auto_trig", auto_trig, e_auto);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) mdl(); else m_reset();
    #1;
    compare();
    if (armed && !armed_prev) armed_at = m_n;
    armed_prev = armed;
  endtask

  task automatic idle();
    smpl_en = 0; arm = 0; trigger = 0; dump_active = 0; clr_done = 0;
  endtask

  task automatic arm_it(input int tp);
    idle();
    trig_pos = AW'(tp);
    arm = 1;
    step();
    arm = 0;
    check("arm_we", we, 1);
  endtask

  task automatic trace(input int t1, input int t2, input int pct, input int exp_end, input bit quiet);
    bit f1, f2;
    int k;
    f1 = 0; f2 = 0; k = 0;
    while (m_ph == 1 && k < 20000) begin
      smpl_en = $urandom_range(99) < pct;
      trigger = 0;
      if (!f1 && m_n >= t1 - 1) begin trigger = 1; f1 = 1; end
      else if (!f2 && m_n >= t2 - 1) begin trigger = 1; f2 = 1; end
      if (trigger && quiet) smpl_en = 0;
      arm = $urandom_range(3) == 0;
      clr_done = $urandom_range(3) == 0;
      dump_active = $urandom_range(1) == 0;
      trig_pos = AW'($urandom);
      step();
      k++;
    end
    idle();
    step();
    check("trace_done", capture_done, 1);
    if (exp_end >= 0) check("trace_end_exp", trace_end, exp_end);
  endtask

  task automatic clear();
    clr_done = 1;
    step();
    clr_done = 0;
    step();
    check("cleared", capture_done, 0);
  endtask

  initial begin
    rst_n = 0; trig_pos = '0; armed_prev = 0; armed_at = -1;
    idle();
    m_reset();
    #12;
    compare();
    check("rst_cap_addr", cap_addr, 0);
    rst_n = 1;
    step();
    // basic capture: armed after 284 writes, trigger on sample 300
    arm_it(100);
    trace(300, BIG, 100, 15, 0);
    check("armed_at_basic", armed_at, 284);
    clear();
    // early trigger ignored, second one completes
    arm_it(100);
    trace(50, 290, 100, 5, 0);
    clear();
    // trig_pos 0, trigger together with a sample and without one
    arm_it(0);
    trace(400, BIG, 100, 15, 0);
    clear();
    arm_it(0);
    trace(390, BIG, 100, 4, 1);
    clear();
    // trig_pos 511 clamps to 383
    arm_it(511);
    trace(2, BIG, 100, 0, 0);
    check("armed_at_clamp", armed_at, 1);
    clear();
    // arm blocked while dump is active
    dump_active = 1; arm = 1;
    repeat (3) step();
    check("dump_we", we, 0);
    idle();
    step();
    // re-arm from DONE in the clr_done cycle
    arm_it(50);
    trace(340, BIG, 100, 5, 0);
    clr_done = 1; arm = 1; trig_pos = AW'(50);
    step();
    idle();
    check("rearm_we", we, 1);
    smpl_en = 1;
    step();
    check("rearm_en", cap_en, 1);
    check("rearm_addr", cap_addr, 0);
    trace(340, BIG, 100, 5, 0);
    clear();
    // randomized traces
    for (int r = 0; r < 6; r++) begin
      int t1;
      t1 = $urandom_range(600);
      arm_it($urandom_range(511));
      trace(t1, D + 1 + $urandom_range(300), 40 + $urandom_range(60), -1, $urandom_range(1) == 1);
      clear();
    end
    // asynchronous reset in POST, then a clean trace
    arm_it(100);
    smpl_en = 1;
    for (int k = 0; k < 2000 && !(m_trig >= 0 && m_n >= m_trig + 10); k++) begin
      trigger = m_n >= 299 && m_trig < 0;
      step();
    end
    idle();
    #2 rst_n = 0;
    #1;
    m_reset();
    compare();
    check("rst_mid_we", we, 0);
    step();
    rst_n = 1;
    step();
    arm_it(100);
    trace(300, BIG, 100, 15, 0);
    clear();
    // no trigger for a long time
    arm_it(0);
    smpl_en = 1;
    repeat (10000) step();
    idle();
`ifdef CAPTURE_AUTOTRIG_EN
    check("auto_trig_set", auto_trig, 1);
    clear();
`else
    check("still_armed", armed, 1);
    trace(0, BIG, 100, -1, 0);
    clear();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequences the capture side of the three channel sample RAMs. It takes a sample strobe, an arm request and a trigger pulse, and produces the write address, write enable and capture/dump select for the RAM interface. When the post-trigger sample count completes, it publishes `trace_end` and `capture_done`; the dump path then reads the circular buffer starting at `trace_end+1`.

## Interface
- `DEPTH`, default 384: number of RAM entries per channel. Addresses are `0..DEPTH-1` and wrap.
- `AW`, default 9: address width. `DEPTH <= 2**AW`.
- `TIMEOUT`, default 4096: sample count for auto-trigger. Used only with `CAPTURE_AUTOTRIG_EN`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `smpl_en` in 1: one-cycle strobe, one new sample per strobe.
- `arm` in 1: level or pulse; requests a new capture.
- `trigger` in 1: one-cycle trigger-event pulse from the trigger logic.
- `trig_pos` in AW: number of samples kept after the trigger. Sampled at arm accept.
- `dump_active` in 1: the RAM dump is in progress. Blocks arm accept.
- `clr_done` in 1: acknowledges `capture_done` and returns the block to idle.
- `we` out 1: capture owns the RAMs (write/select). Reset value 0.
- `cap_en` out 1: RAM enable, one pulse per sample written. Reset value 0.
- `cap_addr` out AW: write address, valid while `cap_en` is high. Reset value 0.
- `trace_end` out AW: address of the last sample of the completed trace. Reset value 0.
- `armed` out 1: the pre-trigger region is full and a trigger is accepted. Reset value 0.
- `capture_done` out 1: a trace is complete and stable. Reset value 0.
- `auto_trig` out 1: the last trace ended on timeout. Present only with `CAPTURE_AUTOTRIG_EN`; otherwise tied to 0. Reset value 0.

## Operation
- State machine states: IDLE, PRE, ARMED, POST, DONE. The state register is reset to IDLE.
- **IDLE**
  - On `arm && !dump_active`: latch `tp = min(trig_pos, DEPTH-1)`, clear `pre_cnt`, `post_cnt` and `wr_ptr`, and go to PRE.
  - `arm` while `dump_active` is high is ignored.
- **PRE, ARMED, POST (write states)**
  - `we` is high.
  - Each `smpl_en` causes one write at `wr_ptr`. `wr_ptr` then increments and wraps from `DEPTH-1` to 0.
  - `pre_cnt` counts writes and saturates at `DEPTH`.
- **PRE to ARMED:** when `pre_cnt >= DEPTH - tp`.
- **ARMED to POST:** on a `trigger` pulse. `post_cnt` counts only writes issued after the trigger cycle.
- A `trigger` in IDLE, PRE, POST or DONE is ignored. No queueing.
- **POST to DONE:** when `post_cnt == tp` and the final write has issued.
  - `trace_end` is loaded with the address of the last write.
  - `tp = 0` gives DONE on the cycle after the trigger, with `trace_end` = the most recent write address.
- **DONE**
  - `we = 0`, `capture_done = 1`, `trace_end` is held.
  - `clr_done` returns to IDLE.
  - `clr_done && arm && !dump_active` in the same cycle goes straight to PRE (re-arm).
- `arm` during PRE, ARMED or POST is ignored.
- A trace is always `DEPTH` samples: `DEPTH - tp` pre-trigger samples and `tp` post-trigger samples.
- All arithmetic is unsigned, AW bits. Wrap is explicit compare-to-`DEPTH-1`, not a power-of-2 rollover.

## Timing
- All outputs are registered.
- `smpl_en` in cycle t gives `cap_en = 1` in cycle t+1, with `cap_addr` = the pre-increment `wr_ptr`.
- `we` rises in the cycle after arm accept and is low in the cycle DONE is entered. `we` is high on every `cap_en` cycle.
- `armed` is high exactly in ARMED.
- `trigger` and `smpl_en` in the same cycle in ARMED: that sample is a pre-trigger sample and is not counted in `post_cnt`.
- `capture_done` rises in the cycle after the final `cap_en` pulse and falls in the cycle after `clr_done`.
- Reset mid-capture: all outputs return to their reset values immediately (async). No partial `trace_end` is published.
- `smpl_en` in IDLE or DONE produces no `cap_en`.

## Configuration
- **`CAPTURE_AUTOTRIG_EN` defined**
  - In ARMED, a counter counts `smpl_en`. It reaches `TIMEOUT` with no trigger, then forces a trigger.
  - `auto_trig` is set on entry to POST by timeout and cleared at arm accept.
- **Not defined:** ARMED waits indefinitely and `auto_trig` is constant 0.

## Test plan
- Basic capture, DEPTH=384, `trig_pos=100`, `smpl_en` every cycle, arm:
  - `armed` rises after 284 writes.
  - Trigger at sample 300 gives 100 further writes, then `capture_done`.
  - `trace_end` = (400-1) mod 384 = 15.
- Early trigger: trigger pulse at sample 50 with `trig_pos=100`.
  - The trigger is ignored.
  - A second trigger at sample 290 completes the trace, `trace_end` = 5.
- Edge values of `trig_pos`:
  - `trig_pos=0`: trigger after `armed` gives `capture_done` one cycle later, `trace_end` = the last write address.
  - `trig_pos=511`: clamped to 383, so `armed` after 1 write.
- Arm gating and re-arm:
  - Arm with `dump_active=1` gives no `we` and the block stays idle.
  - In DONE, `clr_done` and `arm` in the same cycle give `we` high the next cycle with `wr_ptr=0`.
- Reset mid-capture: `rst_n` low in POST.
  - All outputs go to 0 asynchronously.
  - After release, arm runs a full clean trace.
- `CAPTURE_AUTOTRIG_EN`, `TIMEOUT=16`, no trigger:
  - POST is entered 16 samples after `armed` and `auto_trig=1`.
  - Without the macro, the block is still ARMED after 10000 samples.
